click_classifier: RTL
=====================

// Module: click_classifier
// PURPOSE
//  Consumes the 1-cycle press pulse from the button debouncer and groups presses into
//  click events: single, double or triple. Presses closer together than WINDOW_CYCLES
//  join one event. Each event reaches the control logic over a valid/ready handshake.
// PARAMETERS
//  WINDOW_CYCLES  20000  idle cycles after the last press that close a group (>=2)
//  MAX_CLICKS     3      press count that closes a group at once (2..3)
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  asynchronous, active-high; clears all state
//  press        in   1  1-cycle press pulse from the debouncer
//  evt_valid    out  1  an event is held in the output register
//  evt_clicks   out  2  press count of the held event: 1, 2 or 3 (0 only when idle)
//  evt_ready    in   1  consumer accepts the event on a cycle with evt_valid&evt_ready
//  overrun      out  1  1-cycle pulse: an event was dropped because the register was full
// BEHAVIOUR
//  - Single clock. Reset is asynchronous and active-high.
//  - Reset values: state=IDLE, timer=0, click_cnt=0, evt_valid=0, evt_clicks=0, overrun=0.
//  - FSM has two states:
//    IDLE: a press loads click_cnt=1 and timer=0, then goes to GROUP.
//    GROUP: each cycle, timer increments.
//      A press clears timer and sets click_cnt to click_cnt+1.
//      The group closes when timer==WINDOW_CYCLES-1 with no press, or when a press
//      makes click_cnt reach MAX_CLICKS.
//      Closing emits the count and returns to IDLE.
//  - Timing: a press in cycle t with no later presses gives evt_valid=1 in cycle t+WINDOW_CYCLES+1.
//    A closing press at MAX_CLICKS in cycle t gives evt_valid=1 in cycle t+1.
//  - Timer width is $clog2(WINDOW_CYCLES). The timer never wraps, because it stops at the
//    terminal value. click_cnt is 2 bits and never exceeds MAX_CLICKS.
//  - Output register:
//    An emit loads evt_valid and evt_clicks when the register is empty, or when the held
//    event is accepted in the same cycle (back-to-back allowed).
//    Otherwise the new event is dropped, the held event is kept, and overrun pulses 1 cycle.
//    evt_clicks is stable while evt_valid=1 and evt_ready=0.
//    Accepting with no new emit clears evt_valid and sets evt_clicks to 0.
//  - Press in the same cycle as a timeout: the timeout event is emitted with the old count.
//    The press then starts a new group (click_cnt=1, state GROUP).
//  - A press while in IDLE on the same cycle as an accept is handled as normal. The two
//    paths are independent.
//  - Reset during a group or while an event is held discards everything. No event is
//    emitted after reset is released.
//  - evt_ready is ignored while evt_valid=0.
// STRUCTURE
//  - click_pkg holds:
//    state enum typedef {IDLE, GROUP};
//    localparam CLICK_W=2;
//    localparam for the event codes SINGLE=1, DOUBLE=2, TRIPLE=3.
//  - One sub-module: click_evt_reg, the one-entry valid/ready holding register with overrun.
//  - The FSM, timer and counter stay in click_classifier.
// TESTING  (WINDOW_CYCLES=8, MAX_CLICKS=3)
//  - Reset, idle 50 cycles -> evt_valid=0, overrun=0 throughout.
//  - Press @t=10, ready=1 -> evt_valid=1 with evt_clicks=1 only in cycle 19, 1 cycle wide.
//  - Presses @10,@14 -> evt_clicks=2, valid in cycle 23.
//    Presses @10,@14,@18 -> evt_clicks=3, valid in cycle 19.
//  - Press @10, ready=0; press @30 -> first event (clicks=1) held from cycle 19.
//    Second emit in cycle 39 -> overrun=1 in cycle 39, evt_clicks still 1.
//  - Press @10 and press @18 (the timeout cycle) -> event clicks=1 in cycle 19.
//    Second event clicks=1 in cycle 27.
//  - Presses @10,@12, reset high in cycles 13-14 -> no event and no overrun through cycle 40.

Source files
------------

// File: rtl/click_pkg.sv
// -----------------------------------------------------------------------------
// click_pkg
// Shared types and constants for the click classifier.
//   state_t  : classifier FSM states (IDLE waits for a first press, GROUP
//              collects presses until the window expires or the count tops out)
//   CLICK_W  : width of the click count carried with each event
//   SINGLE / DOUBLE / TRIPLE : event codes placed on evt_clicks
// -----------------------------------------------------------------------------
package click_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GROUP = 1'b1
    } state_t;

    localparam int CLICK_W = 2;

    localparam logic [CLICK_W-1:0] SINGLE = 2'd1;
    localparam logic [CLICK_W-1:0] DOUBLE = 2'd2;
    localparam logic [CLICK_W-1:0] TRIPLE = 2'd3;

endpackage

// File: rtl/click_evt_reg.sv
// -----------------------------------------------------------------------------
// click_evt_reg
// One-entry valid/ready holding register for click events.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   i_emit     in   a new event is offered this cycle
//   i_clicks   in   click count of the offered event
//   i_ready    in   consumer accepts the held event (only meaningful when o_valid)
//   o_valid    out  an event is held
//   o_clicks   out  click count of the held event, 0 when empty
//   o_overrun  out  1-cycle pulse: the offered event was dropped (register full)
// -----------------------------------------------------------------------------
module click_evt_reg
    import click_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_emit,
    input  logic [CLICK_W-1:0] i_clicks,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [CLICK_W-1:0] o_clicks,
    output logic               o_overrun
);

    logic               r_valid;
    logic [CLICK_W-1:0] r_clicks;
    logic               r_overrun;
    logic               w_accept;

    // i_ready only matters while something is held.
    assign w_accept = r_valid && i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_clicks  <= '0;
            r_overrun <= 1'b0;
        end else begin
            // A full register that is not being drained drops the new event.
            r_overrun <= i_emit && r_valid && !i_ready;
            if (i_emit && (!r_valid || i_ready)) begin
                r_valid  <= 1'b1;
                r_clicks <= i_clicks;
            end else if (w_accept) begin
                r_valid  <= 1'b0;
                r_clicks <= '0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_clicks  = r_clicks;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/click_classifier.sv
// -----------------------------------------------------------------------------
// click_classifier
// Groups debounced 1-cycle press pulses into single/double/triple click events.
// A group closes after WINDOW_CYCLES idle cycles since its last press, or at
// once when a press brings the count to MAX_CLICKS.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high; clears all state
//   press       in   1-cycle press pulse
//   evt_valid   out  an event is held for the consumer
//   evt_clicks  out  click count of the held event (0 when idle)
//   evt_ready   in   consumer accepts when evt_valid & evt_ready
//   overrun     out  1-cycle pulse: an event was dropped because one was held
// -----------------------------------------------------------------------------
module click_classifier
    import click_pkg::*;
#(
    parameter int WINDOW_CYCLES = 20000,
    parameter int MAX_CLICKS    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               press,
    output logic               evt_valid,
    output logic [CLICK_W-1:0] evt_clicks,
    input  logic               evt_ready,
    output logic               overrun
);

    localparam int                 TIMER_W    = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CLICK_W-1:0] CNT_MAX    = CLICK_W'(MAX_CLICKS);

    state_t             r_state;
    state_t             w_state_nx;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nx;
    logic [CLICK_W-1:0] r_cnt;
    logic [CLICK_W-1:0] w_cnt_nx;
    logic [CLICK_W-1:0] w_cnt_inc;
    logic               w_timeout;
    logic               w_full_press;
    logic               w_emit;
    logic [CLICK_W-1:0] w_emit_clicks;

    assign w_cnt_inc    = r_cnt + CLICK_W'(1);
    // Timeout wins over a coinciding press: that press starts the next group.
    assign w_timeout    = (r_state == GROUP) && (r_timer == TIMER_LAST);
    assign w_full_press = (r_state == GROUP) && press && !w_timeout &&
                          (w_cnt_inc == CNT_MAX);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (press) begin
                    w_state_nx = GROUP;
                    w_timer_nx = '0;
                    w_cnt_nx   = SINGLE;
                end
            end
            GROUP: begin
                if (w_timeout) begin
                    w_timer_nx = '0;
                    if (press) begin
                        w_cnt_nx = SINGLE;
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
                end else if (w_full_press) begin
                    w_state_nx = IDLE;
                    w_timer_nx = '0;
                    w_cnt_nx   = '0;
                end else if (press) begin
                    w_timer_nx = '0;
                    w_cnt_nx   = w_cnt_inc;
                end else begin
                    // Stops at TIMER_LAST because reaching it closes the group.
                    w_timer_nx = r_timer + TIMER_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_timer_nx = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Output logic: event offered to the holding register
    always_comb begin
        w_emit        = 1'b0;
        w_emit_clicks = '0;
        if (w_timeout) begin
            w_emit        = 1'b1;
            w_emit_clicks = r_cnt;
        end else if (w_full_press) begin
            w_emit        = 1'b1;
            w_emit_clicks = CNT_MAX;
        end
    end

    click_evt_reg u_evt_reg (
        .clk       (clk),
        .reset     (reset),
        .i_emit    (w_emit),
        .i_clicks  (w_emit_clicks),
        .i_ready   (evt_ready),
        .o_valid   (evt_valid),
        .o_clicks  (evt_clicks),
        .o_overrun (overrun)
    );

endmodule
